// File: rtl/instr_fetch_queue_pkg.sv
// Shared widths, fetch entry layout and decode helpers
// for the instruction fetch queue.
package instr_fetch_queue_pkg;
  localparam int INSTR_W = 16;
  localparam int PC_W    = 32;
  localparam int IADDR_W = 12;
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;

  localparam logic [PC_W-1:0] PC_INC = 32'd1;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [3:0] opcode(
    input logic [INSTR_W-1:0] instr
  );
    return instr[OPC_HI:OPC_LO];
  endfunction
endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch queue bus: imem req/ack side, decode
// valid/ready side and branch redirect.
interface instr_fetch_queue_if;
  import instr_fetch_queue_pkg::*;

  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               imem_req;
  logic [IADDR_W-1:0] imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic               if_ready;
  logic [PC_W-1:0]    fetch_pc;

  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_ack, imem_rdata, if_ready,
    output imem_req, imem_addr,
    output if_valid, if_instr, if_pc,
    output fetch_pc
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output imem_ack, imem_rdata, if_ready,
    input  imem_req, imem_addr,
    input  if_valid, if_instr, if_pc,
    input  fetch_pc
  );
endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// First-word-fall-through prefetch FIFO of
// {pc, instr} entries with synchronous flush.
module fetch_fifo
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: PC, single-outstanding imem read,
// redirect with drop of a stale in-flight read.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                 clock,
  input logic                 reset,
  instr_fetch_queue_if.master bus
);
  logic               outstanding;
  logic               drop;
  logic [PC_W-1:0]    fetch_pc;
  logic [IADDR_W-1:0] req_addr;
  logic               empty;
  logic               full;
  logic               ack;
  logic               issue;
  logic               push;
  logic               pop;
  fetch_entry_t       head;
  fetch_entry_t       wdata;

  assign ack   = outstanding && bus.imem_ack;
  assign issue = !outstanding && !full &&
                 !bus.redirect_valid;
  assign push  = ack && !drop && !bus.redirect_valid;
  assign pop   = !empty && bus.if_ready;
  assign wdata = '{pc: fetch_pc, instr: bus.imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (bus.redirect_valid),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .head  (head),
    .empty (empty),
    .full  (full)
  );

  // req_addr is latched at issue so a redirect cannot
  // move the address of a read already in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outstanding <= 1'b0;
      drop        <= 1'b0;
      fetch_pc    <= '0;
      req_addr    <= '0;
    end else begin
      if (bus.redirect_valid) fetch_pc <= bus.redirect_pc;
      else if (push)          fetch_pc <= fetch_pc + PC_INC;
      if (ack) begin
        outstanding <= 1'b0;
        drop        <= 1'b0;
      end else if (issue) begin
        outstanding <= 1'b1;
        req_addr    <= fetch_pc[IADDR_W-1:0];
      end
      if (bus.redirect_valid && outstanding && !bus.imem_ack)
        drop <= 1'b1;
    end
  end

  assign bus.imem_req  = outstanding;
  assign bus.imem_addr = req_addr;
  assign bus.if_valid  = !empty;
  assign bus.if_instr  = head.instr;
  assign bus.if_pc     = head.pc;
  assign bus.fetch_pc  = fetch_pc;
endmodule
